// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: round counts, key-size encodings,
// FSM states, inverse S-box and GF(2^8) multiply helpers.
package aes_pkg;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    KS_128 = 2'b00,
    KS_192 = 2'b01,
    KS_256 = 2'b10,
    KS_RSV = 2'b11
  } key_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_e;

  // Reserved encoding runs as AES-128; the error flag is raised separately.
  function automatic logic [3:0] nr_of(input logic [1:0] sz);
    case (key_size_e'(sz))
      KS_192:  return NR_192;
      KS_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[(11'd255 - {3'd0, x}) * 11'd8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// InvMixColumns applied to one 32-bit column, byte 0 at [31:24].
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  // Fixed inverse matrix {0e 0b 0d 09} rotated per output row.
  always_comb begin
    mixed[31:24] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
    mixed[23:16] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
    mixed[15:8]  = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
    mixed[7:0]   = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
  end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, AES-128/192/256.
// Optional build macro INV_CIPHER_KEY_LATCH_EN captures the key schedule at
// acceptance so the caller may change key_sched while a block is in flight.
module inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR_MAX = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [127:0]                in_data,
  input  logic [1:0]                  size,
  input  logic [128*(NR_MAX+1)-1:0]   key_sched,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [127:0]                out_data,
  output logic                        out_err
);

  localparam int unsigned KSW = 128 * (NR_MAX + 1);

  fsm_e         fsm;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic         ir_q;
  logic [3:0]   nr_ld;
  logic [127:0] rk_ld;
  logic [127:0] rk_cur;
  logic [127:0] sr, sb, ark, mc;
  logic [KSW-1:0] ks;

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
    end
    return o;
  endfunction

`ifdef INV_CIPHER_KEY_LATCH_EN
  logic [KSW-1:0] ks_q;

  // Snapshot the schedule at acceptance; the first key is taken live.
  always_ff @(posedge clk) begin
    if (!rst && fsm == IDLE && ir_q && in_valid) begin
      ks_q <= key_sched;
    end
  end

  assign ks = ks_q;
`else
  assign ks = key_sched;
`endif

  assign in_ready  = ir_q & ~rst;
  assign out_data  = st;

  // Round datapath and round-key selection.
  always_comb begin
    nr_ld  = nr_of(size);
    rk_ld  = key_sched[(NR_MAX - 32'(nr_ld)) * 128 +: 128];
    rk_cur = ks[(NR_MAX - 32'(rnd)) * 128 +: 128];
    sr     = inv_shift_rows(st);
    sb     = inv_sub_bytes(sr);
    ark    = sb ^ rk_cur;
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    inv_mix_column u_imc (
      .col   (ark[127-32*c -: 32]),
      .mixed (mc[127-32*c -: 32])
    );
  end

  // Control FSM with registered handshake outputs and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      st        <= '0;
      rnd       <= '0;
      ir_q      <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (ir_q && in_valid) begin
            st      <= in_data ^ rk_ld;
            rnd     <= nr_ld - 4'd1;
            out_err <= (key_size_e'(size) == KS_RSV);
            ir_q    <= 1'b0;
            fsm     <= ROUND;
          end
        end
        ROUND: begin
          st <= mc;
          if (rnd == 4'd1) begin
            rnd <= '0;
            fsm <= FINAL;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        FINAL: begin
          st        <= ark;
          out_valid <= 1'b1;
          fsm       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ir_q      <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed self-checking bench for inv_cipher_iter using FIPS-197 vectors.
module tb_inv_cipher_iter;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [1:0]     size;
  logic [1919:0]  key_sched;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic           out_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  inv_cipher_iter #(.NR_MAX(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .size      (size),
    .key_sched (key_sched),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fsbox(input logic [7:0] x);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 254; i++) p = gm(p, x);
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {fsbox(w[31:24]), fsbox(w[23:16]), fsbox(w[15:8]), fsbox(w[7:0])};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1919:0] r;
    int total;
    total = 4 * (nk + 7);
    rcon = 8'h01;
    r = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < total; i++) r[1919-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [127:0] ct, input logic [1919:0] ks, input logic [1:0] sz);
    int n;
    in_data   = ct;
    key_sched = ks;
    size      = sz;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_after_accept", {127'd0, in_ready}, 128'd0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_block(input string tag, input logic [127:0] ct, input logic [1919:0] ks,
                           input logic [1:0] sz, input logic [127:0] pt, input int nr,
                           input logic err);
    int lat;
    out_ready = 1'b1;
    send(ct, ks, sz);
    wait_out(lat);
    chk({tag, "_latency"}, 128'(lat), 128'(nr));
    chk({tag, "_data"}, out_data, pt);
    chk({tag, "_err"}, {127'd0, out_err}, {127'd0, err});
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
    chk({tag, "_ready_back"}, {127'd0, in_ready}, 128'd1);
  endtask

  localparam logic [127:0] CT128 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT128 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTC   = 128'h00112233445566778899aabbccddeeff;

  logic [1919:0] ks128, ks192, ks256;

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; size = 2'b00; key_sched = '0;

    ks128 = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    ks192 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    ks256 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_err", {127'd0, out_err}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

    run_block("aes128", CT128, ks128, 2'b00, PT128, 10, 1'b0);
    run_block("aes192", CT192, ks192, 2'b01, PTC, 12, 1'b0);
    run_block("aes256", CT256, ks256, 2'b10, PTC, 14, 1'b0);

    // Backpressure: hold the sink off while a second block is offered.
    out_ready = 1'b0;
    send(CT128, ks128, 2'b00);
    wait_out(lat);
    chk("bp_latency", 128'(lat), 128'd10);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_data_stable", out_data, PT128);
      chk("bp_valid_held", {127'd0, out_valid}, 128'd1);
      chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {127'd0, out_valid}, 128'd0);
    chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accepted", {127'd0, in_ready}, 128'd0);
    wait_out(lat);
    chk("bp_second_latency", 128'(lat), 128'd10);
    chk("bp_second_data", out_data, PT128);
    @(posedge clk); #1;

    // Reset sampled at E5 of an AES-128 block.
    send(CT128, ks128, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_data", out_data, 128'd0);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_back", {127'd0, in_ready}, 128'd1);
    run_block("after_rst", CT128, ks128, 2'b00, PT128, 10, 1'b0);

    run_block("reserved", CT128, ks128, 2'b11, PT128, 10, 1'b1);
    run_block("err_clears", CT128, ks128, 2'b00, PT128, 10, 1'b0);

`ifdef INV_CIPHER_KEY_LATCH_EN
    out_ready = 1'b1;
    send(CT128, ks128, 2'b00);
    key_sched = '0;
    wait_out(lat);
    chk("latch_latency", 128'(lat), 128'd10);
    chk("latch_data", out_data, PT128);
    @(posedge clk); #1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inv_cipher_iter.md
# inv_cipher_iter

Iterative AES inverse cipher (FIPS-197 decryption), one round per clock, for 128-, 192- and 256-bit keys. It is the receive-side counterpart to the combinational encryption path: it takes a 128-bit ciphertext block plus the expanded key schedule in the same packed layout the encryption key expansion produces, and returns the plaintext. Both sides use a valid/ready handshake, so it can sit between a ciphertext source and a plaintext sink with backpressure.

## Interface
- `NR_MAX`, default 14: maximum round count; sets schedule width to 128*(NR_MAX+1).
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: ciphertext block offered.
- `in_ready` out 1: block accepted when `in_valid & in_ready` at an edge.
- `in_data` in 128: ciphertext, byte 0 at [127:120].
- `size` in 2: key size. `00` is AES-128 (Nr=10), `01` is AES-192 (Nr=12), `10` is AES-256 (Nr=14), `11` is reserved.
- `key_sched` in 1920: round key i at [1919-128*i -: 128]; keys above Nr are ignored.
- `out_valid` out 1: plaintext available.
- `out_ready` in 1: sink accepts when `out_valid & out_ready` at an edge.
- `out_data` out 128: plaintext.
- `out_err` out 1: qualified by `out_valid`; high when `size` was `11` at acceptance.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - `in_ready` = 1.
  - On input handshake: latch `size`. Load state = `in_data ^ rk[Nr]`. Round counter r = Nr-1. Go to ROUND.
- ROUND, one per edge:
  - state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
  - Decrement r.
  - When r reaches 1 and its round completes, go to FINAL.
- FINAL: state = InvSubBytes(InvShiftRows(state)) ^ rk[0]. Go to DONE.
- DONE:
  - `out_valid` = 1 and `out_data` = state.
  - `out_data` is held stable until the output handshake, then return to IDLE.
- `size` = `11` runs as Nr=10 and sets `out_err` for that block.
- `in_ready` is 0 in ROUND, FINAL and DONE. There is no overlap between blocks.
- Unless the configuration macro is defined, `key_sched` must stay stable from the acceptance edge until the output handshake.
- Reset at any state:
  - Next state is IDLE.
  - `out_valid`, `out_err` and `out_data` go to 0, and any in-flight block is discarded.
  - `in_ready` is forced 0 while `rst` is high.
- Reset values: `in_ready` 0 while in reset and 1 after; `out_valid` 0; `out_data` 128'h0; `out_err` 0.

## Timing
- Acceptance edge is E0. ROUND occupies edges E1..E(Nr-1); FINAL is edge E(Nr).
- `out_valid` rises after E(Nr): latency 10, 12 or 14 cycles.
- If `out_ready` is already high, the output handshake happens at E(Nr+1) and `in_ready` is high after it.
- Peak throughput is one block per Nr+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready`.
- If `out_ready` stalls, DONE holds indefinitely with no change to outputs.

## Configuration
- `INV_CIPHER_KEY_LATCH_EN`:
  - Defined: the needed round keys of `key_sched` are captured into an internal 1920-bit register at E0. The caller may change `key_sched` any time after acceptance.
  - Undefined: no capture register. `key_sched` is read live, and the stability rule above applies.
  - Ports and latency are identical in both builds.

## Structure
- Shared package `aes_pkg` holds:
  - Nr constants.
  - `size` encodings.
  - FSM state enum.
  - Inverse S-box function.
  - GF(2^8) helpers: xtime, mul9, mul11, mul13, mul14.
- One sub-module, `inv_mix_column`: combinational 32-bit column transform, instantiated 4 times.
- InvShiftRows, InvSubBytes and round-key select stay in the top module.

## Test plan
- AES-128: ct 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c (schedule from the encryption key expansion), `size` 00 -> `out_data` 3243f6a8885a308d313198a2e0370734, `out_valid` 10 cycles after E0, `out_err` 0.
- AES-192: ct dda97ca4864cdfe06eaf70a0ec0d7191, key 000102…1617, `size` 01 -> 00112233445566778899aabbccddeeff after 12 cycles.
- AES-256: ct 8ea2b7ca516745bfeafc49904b496089, key 000102…1e1f, `size` 10 -> 00112233445566778899aabbccddeeff after 14 cycles.
- Backpressure: hold `out_ready` 0 for 20 cycles after `out_valid` -> `out_data` stable, `in_ready` 0, a second `in_valid` not accepted. Release -> handshake, then the second block is accepted next cycle.
- Reset mid-round: assert `rst` at E5 of an AES-128 block -> `out_valid` 0, `out_data` 0 after the edge. Next block decrypts correctly.
- Reserved size: `size` 11 with the AES-128 vector -> `out_err` 1 with `out_valid`. With `INV_CIPHER_KEY_LATCH_EN`, zeroing `key_sched` at E1 still yields 3243f6a8885a308d313198a2e0370734.
